// File: rtl/fsm_pkg.sv
// Shared definitions between the serial code framer and the sequence-detect FSM it feeds.
package fsm_pkg;

  // Code shown on the FSM input when nothing is presented ("hold state").
  localparam logic [2:0] IDLE_CODE = 3'b000;
  // Codes the downstream FSM reacts to.
  localparam logic [2:0] IN_1      = 3'b011;
  localparam logic [2:0] IN_0      = 3'b100;

  // Framer state: FILL while collecting W fresh bits, RUN once the window is valid.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } framer_state_t;

endpackage

// File: rtl/code_fifo.sv
// Small W x DEPTH FIFO holding framed codes. A pop frees its slot before a push in the
// same cycle, so a full FIFO accepts a push when it is popped at the same edge.
// Pointers carry one extra wrap bit; full = wrap bits differ, index bits equal.
module code_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_code_framer.sv
// Deserialises a serial bit stream into W-bit codes (MSB first) for the sequence-detect FSM.
// Sliding mode emits a code per valid bit once W bits are held; block mode emits one code
// per W bits. Codes are queued in a small FIFO; dropped codes are flagged and counted.
//
// Handshake: out_valid is high whenever the FIFO holds a code and out_code then shows the
// head; a transfer happens on a rising edge where out_valid & out_ready, and out_code is
// held stable while out_valid=1 and out_ready=0. out_ready while out_valid=0 is ignored.
// bit_valid has no backpressure: every valid bit is accepted.
module serial_code_framer #(
  parameter int             W         = 3,
  parameter int             DEPTH     = 2,
  parameter logic [W-1:0]   IDLE_CODE = fsm_pkg::IDLE_CODE,
  parameter int             CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             mode,
  input  logic             out_ready,
  input  logic             clear_ovf,
  output logic [W-1:0]     out_code,
  output logic             out_valid,
  output logic             window_full,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count
);

  import fsm_pkg::*;

  localparam int FW = (W > 2) ? $clog2(W) : 1;
  localparam logic [FW-1:0] LAST_FILL = FW'(W - 1);

  framer_state_t state;
  logic          mode_q;
  logic [W-1:0]  window;
  logic [FW-1:0] fill;
  logic [W-1:0]  next_window;
  logic          mode_change;
  logic          emit;
  logic          pop;
  logic          drop;
  logic [W-1:0]  fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  assign next_window = {window[W-2:0], bit_in};
  assign mode_change = (mode != mode_q);
  assign out_valid   = !fifo_empty;
  assign out_code    = out_valid ? fifo_head : IDLE_CODE;
  assign window_full = (state == RUN);
  assign pop         = out_valid && out_ready;
  assign drop        = emit && fifo_full && !pop;

  // Decide whether the bit sampled this cycle completes a code.
  always_comb begin
    emit = 1'b0;
    if (bit_valid && !mode_change) begin
      if (state == RUN && !mode_q) emit = 1'b1;
      else                         emit = (fill == LAST_FILL);
    end
  end

  // Framing FSM and shift window; a mode change restarts the fill count but keeps bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FILL;
      mode_q <= 1'b0;
      window <= '0;
      fill   <= '0;
    end else begin
      mode_q <= mode;
      if (bit_valid) window <= next_window;
      if (mode_change) begin
        state <= FILL;
        fill  <= '0;
      end else if (bit_valid && (state == FILL || mode_q)) begin
        if (fill == LAST_FILL) begin
          state <= RUN;
          fill  <= '0;
        end else begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf)              drop_count <= CNT_W'(1);
      else if (drop_count != '1)  drop_count <= drop_count + 1'b1;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  code_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (emit),
    .pop   (pop),
    .din   (next_window),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_serial_code_framer.sv
// Bench for serial_code_framer: directed scenarios plus a random phase, all checked against
// a reference model of the framer and an expected-code queue standing in for the FIFO.
module tb_serial_code_framer;

  localparam int W     = 3;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam logic [W-1:0] IDLE = fsm_pkg::IDLE_CODE;

  logic             clock;
  logic             reset;
  logic             bit_in;
  logic             bit_valid;
  logic             mode;
  logic             out_ready;
  logic             clear_ovf;
  logic [W-1:0]     out_code;
  logic             out_valid;
  logic             window_full;
  logic             overflow;
  logic [CNT_W-1:0] drop_count;

  serial_code_framer #(
    .W         (W),
    .DEPTH     (DEPTH),
    .IDLE_CODE (IDLE),
    .CNT_W     (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .mode        (mode),
    .out_ready   (out_ready),
    .clear_ovf   (clear_ovf),
    .out_code    (out_code),
    .out_valid   (out_valid),
    .window_full (window_full),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // reference model of the framer
  logic [W-1:0] m_win    = '0;
  int           m_fill   = 0;
  bit           m_run    = 1'b0;
  bit           m_mode_q = 1'b0;
  bit           m_ovf    = 1'b0;
  int           m_drops  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_win = '0; m_fill = 0; m_run = 1'b0; m_mode_q = 1'b0; m_ovf = 1'b0; m_drops = 0;
  endtask

  // One clock cycle: check visible outputs, drive inputs, advance the model, clock the DUT.
  task automatic step(input bit v, input bit b, input bit rdy, input bit md,
                      input bit clr, input bit rst);
    logic [W-1:0] nw;
    bit emit;
    bit dropped;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_code", out_code, exp_q[0]);
    else                   check("out_code_idle", out_code, IDLE);
    check("window_full", window_full, m_run);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);
    if (out_valid && rdy) seen_q.push_back(out_code);

    reset = rst; bit_valid = v; bit_in = b; out_ready = rdy; mode = md; clear_ovf = clr;

    if (rst) begin
      model_reset();
    end else begin
      emit = 1'b0; dropped = 1'b0;
      nw = {m_win[W-2:0], b};
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (md != m_mode_q) begin
        m_mode_q = md; m_fill = 0; m_run = 1'b0;
        if (v) m_win = nw;
      end else if (v) begin
        m_win = nw;
        if (m_run && !md) emit = 1'b1;
        else begin
          m_fill++;
          if (m_fill == W) begin m_fill = 0; m_run = 1'b1; emit = 1'b1; end
        end
      end
      if (emit) begin
        if (exp_q.size() == DEPTH) begin
          dropped = 1'b1;
          m_ovf = 1'b1;
          if (clr)                           m_drops = 1;
          else if (m_drops < (1 << CNT_W) - 1) m_drops++;
        end else begin
          exp_q.push_back(nw);
        end
      end
      if (clr && !dropped) begin m_ovf = 1'b0; m_drops = 0; end
    end
    @(posedge clock);
    #1;
  endtask

  // driver: send n bits of pat MSB first
  task automatic send(input logic [15:0] pat, input int n, input bit rdy, input bit md);
    for (int i = n - 1; i >= 0; i--) step(1'b1, pat[i], rdy, md, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy, input bit md);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, md, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit md);
    step(1'b0, 1'b0, 1'b0, md, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, md, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
    mode = 1'b0; clear_ovf = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, IDLE);
    check("rst_window_full", window_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);

    // sliding mode, bits 0,1,1,0,0
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    seen_q.delete();
    send(16'b01100, 5, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    check("t1_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("t1_code0", seen_q[0], fsm_pkg::IN_1);
      check("t1_code1", seen_q[1], 3'b110);
      check("t1_code2", seen_q[2], fsm_pkg::IN_0);
    end

    // block mode, bits 0,1,1,1,0,0
    do_reset(1'b1);
    idle(1, 1'b1, 1'b1);
    seen_q.delete();
    send(16'b01, 2, 1'b1, 1'b1);
    check("t2_wf_before", window_full, 0);
    send(16'b1, 1, 1'b1, 1'b1);
    check("t2_wf_after", window_full, 1);
    send(16'b100, 3, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    check("t2_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("t2_code0", seen_q[0], fsm_pkg::IN_1);
      check("t2_code1", seen_q[1], fsm_pkg::IN_0);
    end

    // stalled consumer, sliding mode: 2 codes held, 4 dropped
    do_reset(1'b0);
    send(16'b10110010, 8, 1'b0, 1'b0);
    check("t3_overflow", overflow, 1);
    check("t3_drops", drop_count, 4);
    check("t3_head", out_code, 3'b101);
    idle(2, 1'b0, 1'b0);
    check("t3_head_stable", out_code, 3'b101);

    // full FIFO with push and pop together: no drop, head advances
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_drops", drop_count, 4);
    check("t4_head", out_code, fsm_pkg::IN_1);
    idle(3, 1'b1, 1'b0);

    // mode toggle after 2 bits in RUN
    do_reset(1'b0);
    send(16'b11010, 5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_wf_dropped", window_full, 0);
    idle(1, 1'b1, 1'b1);
    seen_q.delete();
    send(16'b01, 2, 1'b1, 1'b1);
    idle(1, 1'b1, 1'b1);
    check("t5_no_code_yet", seen_q.size(), 0);
    send(16'b1, 1, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    check("t5_count", seen_q.size(), 1);
    if (seen_q.size() == 1) check("t5_code", seen_q[0], fsm_pkg::IN_1);

    // reset mid-stream with a full FIFO and a drop recorded
    do_reset(1'b0);
    send(16'b10110, 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_code", out_code, IDLE);
    check("t6_rst_wf", window_full, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_drops", drop_count, 0);

    // clear_ovf in the same cycle as a drop
    send(16'b011011, 6, 1'b0, 1'b0);
    check("t6_pre_drops", drop_count, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_clr_ovf", overflow, 1);
    check("t6_clr_drops", drop_count, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_cleared_ovf", overflow, 0);
    check("t6_cleared_drops", drop_count, 0);

    // random traffic; mode only changes in cycles without a valid bit
    begin
      bit md = 1'b0;
      for (int i = 0; i < 400; i++) begin
        bit v = ($urandom_range(0, 3) != 0);
        if (!v && $urandom_range(0, 15) == 0) md = ~md;
        step(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), md,
             ($urandom_range(0, 19) == 0), 1'b0);
      end
      idle(4, 1'b1, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
